// File: rtl/uart_tx_arb_pkg.sv
// rtl/uart_tx_arb_pkg.sv - shared state type, channel limit and round-robin helper
package uart_tx_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int MAX_CH = 16;

  // First set bit of req strictly after 'last', wrapping modulo num_ch; nearest candidate wins.
  function automatic int rr_next(input logic [MAX_CH-1:0] req, input int last, input int num_ch);
    int c;
    int idx;
    idx = last;
    for (int i = MAX_CH; i >= 1; i--) begin
      c = last + i;
      if (c >= num_ch) c = c - num_ch;
      if (i <= num_ch && req[c[3:0]]) idx = c;
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_chan_arb_rr_pick.sv
// rtl/uart_tx_chan_arb_rr_pick.sv - combinational round-robin priority encoder
module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_last,
  output logic [CH_W-1:0]   o_idx,
  output logic              o_any
);

  logic [MAX_CH-1:0] w_req;

  assign w_req = MAX_CH'(i_req);
  assign o_idx = CH_W'(rr_next(w_req, int'(i_last), NUM_CH));
  assign o_any = |i_req;

endmodule

// File: rtl/uart_tx_chan_arb.sv
// rtl/uart_tx_chan_arb.sv - N-channel round-robin byte arbiter in front of uart_tx
// Optional UART_TX_ARB_SKID_EN adds a one-entry registered output stage.
module uart_tx_chan_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         in_valid,
  input  logic [NUM_CH*DATA_W-1:0]  in_data,
  output logic [NUM_CH-1:0]         in_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  input  logic                      out_ready
);

  localparam int CH_W = $clog2(NUM_CH);
  typedef logic [CH_W-1:0] ch_idx_t;
  localparam ch_idx_t LAST_RST = ch_idx_t'(NUM_CH - 1);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  ch_idx_t           r_grant;
  ch_idx_t           w_grant_nxt;
  ch_idx_t           r_last;
  ch_idx_t           w_last_nxt;
  ch_idx_t           w_pick_base;
  ch_idx_t           w_pick_idx;
  logic              w_pick_any;
  logic              w_sel_valid;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sink_rdy;
  logic              w_accept;

  // While granted, the current owner is the rotation base so it drops to lowest priority on accept.
  assign w_pick_base = (r_state == GRANT) ? r_grant : r_last;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_pick (
    .i_req  (in_valid),
    .i_last (w_pick_base),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  assign w_sel_valid = (r_state == GRANT) && in_valid[r_grant];
  assign w_sel_data  = in_data[r_grant*DATA_W +: DATA_W];
  assign w_accept    = w_sel_valid && w_sink_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= LAST_RST;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = GRANT;
          w_grant_nxt = w_pick_idx;
        end
      end
      GRANT: begin
        if (w_accept) begin
          w_last_nxt = r_grant;
          if (w_pick_any) w_grant_nxt = w_pick_idx;
          else            w_state_nxt = IDLE;
        end else if (!w_sel_valid) begin
          // Requester withdrew before acceptance: release the grant without rotating.
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = '0;
    if (w_accept) in_ready[r_grant] = 1'b1;
  end

`ifdef UART_TX_ARB_SKID_EN
  logic              r_buf_full;
  logic [DATA_W-1:0] r_buf_data;
  ch_idx_t           r_buf_ch;

  assign w_sink_rdy = !r_buf_full || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_full <= 1'b0;
      r_buf_data <= '0;
      r_buf_ch   <= '0;
    end else if (w_accept) begin
      r_buf_full <= 1'b1;
      r_buf_data <= w_sel_data;
      r_buf_ch   <= r_grant;
    end else if (out_ready) begin
      r_buf_full <= 1'b0;
    end
  end

  assign out_valid = r_buf_full;
  assign out_data  = r_buf_data;
  assign out_ch    = r_buf_ch;
`else
  assign w_sink_rdy = out_ready;
  assign out_valid  = w_sel_valid;
  assign out_data   = w_sel_valid ? w_sel_data : '0;
  assign out_ch     = r_grant;
`endif

endmodule

// File: tb/tb_uart_tx_chan_arb.sv
// tb/tb_uart_tx_chan_arb.sv - directed vector bench for uart_tx_chan_arb (both UART_TX_ARB_SKID_EN builds)
module tb_uart_tx_chan_arb;

`ifdef UART_TX_ARB_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in_valid = 4'b0000;
  logic [31:0] in_data = 32'h43A5_2110;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_chan_arb #(
    .NUM_CH (4),
    .DATA_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] v;
    logic       ov;
    logic [1:0] ch;
    logic [7:0] data;
    logic [3:0] ir;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic ov,
                              input logic [1:0] ch, input logic [7:0] d, input logic [3:0] ir);
    vec_t r;
    r.rst = rst; r.v = v; r.ov = ov; r.ch = ch; r.data = d; r.ir = ir;
    return r;
  endfunction

  task automatic cyc(input logic rst, input logic [3:0] v, input logic rdy);
    @(posedge clk);
    #1;
    rst_n     = !rst;
    in_valid  = v;
    out_ready = rdy;
    #1;
  endtask

  task automatic chk(input string name, input logic ov, input logic [1:0] ch, input logic [7:0] d,
                     input logic [3:0] ir, input logic force_all);
    n_vec++;
    if (out_valid !== ov || in_ready !== ir ||
        ((ov || force_all) && (out_ch !== ch || out_data !== d))) begin
      n_bad++;
      $display("FAIL %s: got out_valid=%0b out_ch=%0d out_data=%02h in_ready=%04b, want %0b %0d %02h %04b",
               name, out_valid, out_ch, out_data, in_ready, ov, ch, d, ir);
    end
  endtask

  initial begin
    vec_t prev;
    vec_t exp_e;

    tbl[0]  = mk(1, 4'b1111, 0, 0, 8'h00, 4'b0000);
    tbl[1]  = mk(0, 4'b0100, 0, 0, 8'h00, 4'b0000);
    tbl[2]  = mk(0, 4'b0100, 1, 2, 8'hA5, 4'b0100);
    tbl[3]  = mk(0, 4'b0000, 0, 0, 8'h00, 4'b0000);
    tbl[4]  = mk(1, 4'b1111, 0, 0, 8'h00, 4'b0000);
    tbl[5]  = mk(0, 4'b1111, 0, 0, 8'h00, 4'b0000);
    tbl[6]  = mk(0, 4'b1111, 1, 0, 8'h10, 4'b0001);
    tbl[7]  = mk(0, 4'b1111, 1, 1, 8'h21, 4'b0010);
    tbl[8]  = mk(0, 4'b1111, 1, 2, 8'hA5, 4'b0100);
    tbl[9]  = mk(0, 4'b1111, 1, 3, 8'h43, 4'b1000);
    tbl[10] = mk(0, 4'b1111, 1, 0, 8'h10, 4'b0001);
    tbl[11] = mk(0, 4'b0000, 0, 0, 8'h00, 4'b0000);
    tbl[12] = mk(0, 4'b1010, 0, 0, 8'h00, 4'b0000);
    tbl[13] = mk(0, 4'b1010, 1, 1, 8'h21, 4'b0010);
    tbl[14] = mk(0, 4'b1000, 1, 3, 8'h43, 4'b1000);
    tbl[15] = mk(0, 4'b0001, 0, 0, 8'h00, 4'b0000);
    tbl[16] = mk(0, 4'b0001, 0, 0, 8'h00, 4'b0000);
    tbl[17] = mk(0, 4'b0001, 1, 0, 8'h10, 4'b0001);
    tbl[18] = mk(0, 4'b0000, 0, 0, 8'h00, 4'b0000);
    tbl[19] = mk(0, 4'b0000, 0, 0, 8'h00, 4'b0000);

    // With out_ready held high the registered build shows the same byte stream one cycle later.
    prev = '0;
    for (int i = 0; i < NV; i++) begin
      cyc(tbl[i].rst, tbl[i].v, 1'b1);
      exp_e    = (SKID && !tbl[i].rst) ? prev : tbl[i];
      exp_e.ir = tbl[i].ir;
      chk($sformatf("tbl%0d", i), exp_e.ov, exp_e.ch, exp_e.data, exp_e.ir, tbl[i].rst);
      prev = tbl[i].rst ? '0 : tbl[i];
    end

    // Backpressure: ch1 holds its grant while ch0 waits.
    cyc(1, 4'b0000, 0);
    cyc(0, 4'b0010, 0); chk("bp_idle", 0, 0, 8'h00, 4'b0000, 0);
`ifdef UART_TX_ARB_SKID_EN
    cyc(0, 4'b0011, 0); chk("bp_load", 0, 0, 8'h00, 4'b0010, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 4'b0001, 0); chk($sformatf("bp_hold%0d", k), 1, 1, 8'h21, 4'b0000, 0);
    end
    cyc(0, 4'b0001, 1); chk("bp_accept", 1, 1, 8'h21, 4'b0001, 0);
    cyc(0, 4'b0000, 1); chk("bp_next", 1, 0, 8'h10, 4'b0000, 0);
`else
    for (int k = 0; k < 5; k++) begin
      cyc(0, 4'b0011, 0); chk($sformatf("bp_hold%0d", k), 1, 1, 8'h21, 4'b0000, 0);
    end
    cyc(0, 4'b0011, 1); chk("bp_accept", 1, 1, 8'h21, 4'b0010, 0);
    cyc(0, 4'b0001, 1); chk("bp_next", 1, 0, 8'h10, 4'b0001, 0);
`endif
    cyc(0, 4'b0000, 1); chk("bp_done", 0, 0, 8'h00, 4'b0000, 0);

    // Granted requester withdraws before acceptance; rotation pointer must not move.
    cyc(1, 4'b0000, 0);
`ifdef UART_TX_ARB_SKID_EN
    cyc(0, 4'b1100, 0); chk("vio_idle", 0, 0, 8'h00, 4'b0000, 0);
    cyc(0, 4'b1100, 0); chk("vio_load", 0, 0, 8'h00, 4'b0100, 0);
    cyc(0, 4'b1000, 0); chk("vio_grant", 1, 2, 8'hA5, 4'b0000, 0);
    cyc(0, 4'b0000, 0); chk("vio_drop", 1, 2, 8'hA5, 4'b0000, 0);
    cyc(0, 4'b0000, 1); chk("vio_drain", 1, 2, 8'hA5, 4'b0000, 0);
    cyc(0, 4'b0000, 1); chk("vio_empty", 0, 0, 8'h00, 4'b0000, 0);
    cyc(0, 4'b1111, 1); chk("vio_rearb", 0, 0, 8'h00, 4'b0000, 0);
    cyc(0, 4'b1111, 1); chk("vio_accept", 0, 0, 8'h00, 4'b1000, 0);
    cyc(0, 4'b0000, 1); chk("vio_last", 1, 3, 8'h43, 4'b0000, 0);
`else
    cyc(0, 4'b0100, 1); chk("vio_idle", 0, 0, 8'h00, 4'b0000, 0);
    cyc(0, 4'b1100, 1); chk("vio_pre", 1, 2, 8'hA5, 4'b0100, 0);
    cyc(0, 4'b1000, 0); chk("vio_grant", 1, 3, 8'h43, 4'b0000, 0);
    cyc(0, 4'b0000, 0); chk("vio_drop", 0, 0, 8'h00, 4'b0000, 0);
    cyc(0, 4'b0000, 1); chk("vio_after", 0, 0, 8'h00, 4'b0000, 0);
    cyc(0, 4'b1111, 1); chk("vio_rearb", 0, 0, 8'h00, 4'b0000, 0);
    cyc(0, 4'b1111, 1); chk("vio_last", 1, 3, 8'h43, 4'b1000, 0);
`endif

    // Asynchronous reset while a byte is presented.
    cyc(1, 4'b0000, 0);
    cyc(0, 4'b0010, 0); chk("ar_idle0", 0, 0, 8'h00, 4'b0000, 0);
`ifdef UART_TX_ARB_SKID_EN
    cyc(0, 4'b0010, 0); chk("ar_load", 0, 0, 8'h00, 4'b0010, 0);
    cyc(0, 4'b0000, 0); chk("ar_grant", 1, 1, 8'h21, 4'b0000, 0);
`else
    cyc(0, 4'b0010, 0); chk("ar_grant", 1, 1, 8'h21, 4'b0000, 0);
`endif
    #1 rst_n = 1'b0;
    #1 chk("ar_async", 0, 0, 8'h00, 4'b0000, 1);
    cyc(0, 4'b1111, 1); chk("ar_idle1", 0, 0, 8'h00, 4'b0000, 0);
`ifdef UART_TX_ARB_SKID_EN
    cyc(0, 4'b1111, 1); chk("ar_accept", 0, 0, 8'h00, 4'b0001, 0);
    cyc(0, 4'b0000, 1); chk("ar_first", 1, 0, 8'h10, 4'b0000, 0);
`else
    cyc(0, 4'b1111, 1); chk("ar_first", 1, 0, 8'h10, 4'b0001, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
